range_auto_ctrl: RTL
====================

# range_auto_ctrl

Automatic gain-range initiator for the two-channel sensor path. It watches the 12-bit ADC sample stream, tracks the per-channel peak over a fixed window, and decides whether each channel's range should be halved or doubled. It then issues single-cycle write transactions carrying the new ranges to the range register block. It is the write-side master that drives the range register's `write`/`writedata` port.

## Interface
- `ADC_W`, 12: sample width.
- `WINDOW`, 256: samples per evaluation window; must be ≥2.
- `HI_TH`, 3800: a peak strictly above this halves the range.
- `LO_TH`, 1024: a peak strictly below this doubles the range.
- `SETTLE`, 1024: clock cycles of hold-off after each issued write.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; both channel samples are valid.
- `ch1_data` in ADC_W: channel 1 sample (unsigned).
- `ch2_data` in ADC_W: channel 2 sample (unsigned).
- `write` out 1: one-cycle write strobe to the range register block.
- `writedata` out 16: [7:0] new range1, [15:8] new range2; a byte of 0x00 means "leave unchanged".
- `range1` out 8: shadow of the range1 value last committed.
- `range2` out 8: shadow of the range2 value last committed.

## Operation
- States: ACCUM → EVAL → WRITE → HOLDOFF → ACCUM. EVAL returns straight to ACCUM when neither channel changes.
- **ACCUM**
  - On each `sample_valid`, `peakN <= max(peakN, chN_data)` and the window count increments.
  - After the WINDOW-th sample, the block moves to EVAL.
- **EVAL**, per channel, using the registered peak:
  - If peak > HI_TH and range > 0x01: the new range is range>>1.
  - Else if peak < LO_TH and range ≤ 0x40: the new range is range<<1.
  - Otherwise the channel's byte is 0x00 (no change).
  - A range never leaves the set {0x01, 0x02, …, 0x80}. No other values are possible.
- **WRITE**
  - `write` = 1 for exactly one cycle, with `writedata` = {byte2, byte1}.
  - Any non-zero byte updates `range1`/`range2` on the same edge.
- **HOLDOFF**: counts SETTLE cycles, then clears the peaks and window count and enters ACCUM.
- `sample_valid` is ignored in EVAL, WRITE and HOLDOFF. Those samples are discarded and not counted.
- `writedata` holds its last value while `write` = 0. The receiver qualifies data on `write` only.

## Timing
- Reset values:
  - `write` = 0, `writedata` = 0x0000, `range1` = `range2` = 0x80.
  - Peaks = 0, window count = 0, state ACCUM (or RESYNC, see Configuration).
- Latency:
  - The last window sample is accepted at edge t.
  - EVAL occupies cycle t+1.
  - `write` is high during cycle t+2; the shadow ranges update at that edge.
  - HOLDOFF covers cycles t+3 … t+2+SETTLE, and ACCUM resumes at t+3+SETTLE.
- No-change window: the block is back in ACCUM at t+2 with peaks cleared, and no hold-off is applied.
- Back-to-back windows: the minimum spacing between writes is WINDOW sample strobes plus SETTLE+2 cycles.
- Reset mid-operation: `reset_n` low clears all state immediately, including a `write` in flight. No partial transaction survives.
- The receiver has no back-pressure. Every `write` cycle is a committed transaction.

## Configuration
- `RANGE_AUTO_RESYNC_EN` defined:
  - After reset release, the block enters a RESYNC state.
  - On the first clock cycle it issues one write with `writedata` = 0x8080, then enters HOLDOFF.
  - This forces the receiver to agree with the 0x80/0x80 shadows.
- Not defined: there is no RESYNC state, and the block starts in ACCUM with no write after reset.

## Test plan
- **No change:** reset, then 256 strobes with ch1 = ch2 = 2000 → `write` never asserts; ranges stay 0x80/0x80.
- **Halve one channel:** a window with a ch1 peak of 4000 and ch2 = 2000 → one-cycle `write` two cycles after the last strobe, `writedata` = 0x0040, `range1` = 0x40, `range2` = 0x80.
- **Double after halving:**
  - First window: ch2 peak 500 with range2 = 0x80 → no write.
  - Then a high ch2 window → `writedata` = 0x4000.
  - Then a ch2 = 500 window → `writedata` = 0x8000, `range2` = 0x80.
- **Lower floor:** eight consecutive ch1 = 4095 windows → seven writes (0x40 … 0x01); the eighth produces no write, and `range1` = 0x01.
- **Hold-off discard:** ch1 = 4000 strobes during HOLDOFF followed by a 2000-level window → no write; the window count excludes the hold-off strobes.
- **Reset behaviour:** `reset_n` pulsed low during WRITE → `write` drops asynchronously and ranges return to 0x80. With `RANGE_AUTO_RESYNC_EN`, `write` = 1 with 0x8080 in the first cycle after release.

Source files
------------

// File: rtl/range_auto_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : range_auto_ctrl_if                                 |
// | Description : Bundles the ADC sample stream and the range-       |
// |               register write port. The master side is the        |
// |               automatic range controller.                        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface range_auto_ctrl_if #(
  parameter int ADC_W = 12
);
  logic             sample_valid;
  logic [ADC_W-1:0] ch1_data;
  logic [ADC_W-1:0] ch2_data;
  logic             write;
  logic [15:0]      writedata;

  modport master (
    input  sample_valid, ch1_data, ch2_data,
    output write, writedata
  );

  modport slave (
    output sample_valid, ch1_data, ch2_data,
    input  write, writedata
  );
endinterface
`default_nettype wire

// File: rtl/range_auto_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : range_auto_ctrl                                    |
// | Description : Tracks per-channel ADC peaks over a sample window  |
// |               and issues one-cycle writes that halve or double   |
// |               each channel's range. Optional macro               |
// |               RANGE_AUTO_RESYNC_EN adds a resync write of 0x8080 |
// |               after reset release.                               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module range_auto_ctrl #(
  parameter int ADC_W  = 12,
  parameter int WINDOW = 256,
  parameter int HI_TH  = 3800,
  parameter int LO_TH  = 1024,
  parameter int SETTLE = 1024
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  range_auto_ctrl_if.master  bus,
  output logic [7:0]         range1,
  output logic [7:0]         range2
);

  localparam int WCNT_W = $clog2(WINDOW + 1);
  localparam int HCNT_W = $clog2(SETTLE + 1);
  localparam logic [ADC_W-1:0]  c_hi_th    = ADC_W'(HI_TH);
  localparam logic [ADC_W-1:0]  c_lo_th    = ADC_W'(LO_TH);
  localparam logic [WCNT_W-1:0] c_win_last = WCNT_W'(WINDOW - 1);
  localparam logic [HCNT_W-1:0] c_hld_last = HCNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_ACCUM   = 3'd0,
    ST_EVAL    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_RESYNC  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADC_W-1:0]  r_peak1;
  logic [ADC_W-1:0]  r_peak2;
  logic [WCNT_W-1:0] r_win_cnt;
  logic [HCNT_W-1:0] r_hld_cnt;
  logic              r_write;
  logic [15:0]       r_writedata;
  logic [7:0]        r_range1;
  logic [7:0]        r_range2;
  logic [7:0]        w_byte1;
  logic [7:0]        w_byte2;

  // New range byte for one channel; 0x00 means the range stays as it is.
  // The bounds keep the range inside the one-hot set 0x01..0x80.
  function automatic logic [7:0] next_byte(input logic [ADC_W-1:0] peak,
                                           input logic [7:0]       rng);
    if (peak > c_hi_th && rng > 8'h01)
      next_byte = rng >> 1;
    else if (peak < c_lo_th && rng <= 8'h40)
      next_byte = rng << 1;
    else
      next_byte = 8'h00;
  endfunction

  assign w_byte1       = next_byte(r_peak1, r_range1);
  assign w_byte2       = next_byte(r_peak2, r_range2);
  assign bus.write     = r_write;
  assign bus.writedata = r_writedata;
  assign range1        = r_range1;
  assign range2        = r_range2;

  // Window accumulation, evaluation, write issue and settle hold-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef RANGE_AUTO_RESYNC_EN
      r_state     <= ST_RESYNC;
`else
      r_state     <= ST_ACCUM;
`endif
      r_peak1     <= '0;
      r_peak2     <= '0;
      r_win_cnt   <= '0;
      r_hld_cnt   <= '0;
      r_write     <= 1'b0;
      r_writedata <= 16'h0000;
      r_range1    <= 8'h80;
      r_range2    <= 8'h80;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (bus.sample_valid) begin
            if (bus.ch1_data > r_peak1) r_peak1 <= bus.ch1_data;
            if (bus.ch2_data > r_peak2) r_peak2 <= bus.ch2_data;
            r_win_cnt <= r_win_cnt + 1'b1;
            if (r_win_cnt == c_win_last) r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (w_byte1 != 8'h00 || w_byte2 != 8'h00) begin
            r_write     <= 1'b1;
            r_writedata <= {w_byte2, w_byte1};
            if (w_byte1 != 8'h00) r_range1 <= w_byte1;
            if (w_byte2 != 8'h00) r_range2 <= w_byte2;
            r_state     <= ST_WRITE;
          end else begin
            // Nothing to change: start the next window without hold-off.
            r_peak1   <= '0;
            r_peak2   <= '0;
            r_win_cnt <= '0;
            r_state   <= ST_ACCUM;
          end
        end
        ST_WRITE: begin
          r_hld_cnt <= '0;
          r_state   <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (r_hld_cnt == c_hld_last) begin
            r_peak1   <= '0;
            r_peak2   <= '0;
            r_win_cnt <= '0;
            r_state   <= ST_ACCUM;
          end else begin
            r_hld_cnt <= r_hld_cnt + 1'b1;
          end
        end
`ifdef RANGE_AUTO_RESYNC_EN
        ST_RESYNC: begin
          // Force the receiver to match the 0x80/0x80 reset shadows.
          r_write     <= 1'b1;
          r_writedata <= 16'h8080;
          r_state     <= ST_WRITE;
        end
`endif
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
